// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmit and receive paths.
// Holds the one-hot state encoding, oversampling constants, data-length
// encoding and a couple of small helper functions.
package uart_pkg;

   // One-hot state codes, shared with the transmitter
   localparam logic [4:0] ST_IDLE   = 5'b00001;
   localparam logic [4:0] ST_START  = 5'b00010;
   localparam logic [4:0] ST_DATA   = 5'b00100;
   localparam logic [4:0] ST_PARITY = 5'b01000;
   localparam logic [4:0] ST_STOP   = 5'b10000;

   typedef enum logic [4:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } uart_state_t;

   // Oversampling: 16 ticks per bit, start validated at tick 7, others at tick 15
   localparam int         OVERSAMPLE   = 16;
   localparam logic [3:0] START_SAMPLE = 4'd7;
   localparam logic [3:0] BIT_SAMPLE   = 4'd15;

   // Data-length encoding: data bits = 5 + value
   localparam logic [1:0] LEN_5 = 2'd0;
   localparam logic [1:0] LEN_6 = 2'd1;
   localparam logic [1:0] LEN_7 = 2'd2;
   localparam logic [1:0] LEN_8 = 2'd3;

   // Index of the last (most significant) data bit for a given length code
   function automatic logic [2:0] last_bit_idx(input logic [1:0] len);
      logic [2:0] idx;
      case (len)
         LEN_5:   idx = 3'd4;
         LEN_6:   idx = 3'd5;
         LEN_7:   idx = 3'd6;
         LEN_8:   idx = 3'd7;
         default: idx = 3'd7;
      endcase
      return idx;
   endfunction

   // 2-of-3 majority vote
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_recv_sync.sv
// uart_recv_sync: SYNC_STAGES-deep bit synchronizer for the serial input.
// Flops reset to 1 so the line looks idle (high) straight out of reset.
module uart_recv_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic sys_clk,
   input  logic rst_b,
   input  logic i_async,
   output logic o_sync
);

   logic [SYNC_STAGES-1:0] r_sync;

   // Shift the asynchronous line through the flop chain, idle-high on reset
   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receive.sv
// uart_receive: UART serial receive stage with 16x oversampling.
// Validates the start bit at mid-bit, shifts in 5-8 data bits LSB first,
// checks optional parity and the first stop bit, then presents the character
// with parity/framing/break status as a one-cycle valid pulse.
// Optional build macro UART_RECV_MAJORITY_EN: each sample point takes a
// 2-of-3 majority of the synchronized line over the last three ticks.
module uart_receive
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       sys_clk,
   input  logic       rst_b,
   input  logic       s_in,
   input  logic       recv_clk_en,
   input  logic [1:0] ctrl_recv_data_length,
   input  logic       ctrl_recv_parity_en,
   input  logic       ctrl_recv_parity_bit,
   output logic [7:0] recv_ctrl_data,
   output logic       recv_ctrl_data_vld,
   output logic       recv_ctrl_parity_err,
   output logic       recv_ctrl_frame_err,
   output logic       recv_ctrl_break,
   output logic       recv_ctrl_busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);

   logic              w_s_sync;
   logic              w_sample;
   logic [7:0]        w_shift_in;

   uart_state_t       r_state;
   uart_state_t       w_state_nxt;
   logic [TICK_W-1:0] r_tick;
   logic [TICK_W-1:0] w_tick_nxt;
   logic [2:0]        r_bit_cnt;
   logic [2:0]        w_bit_cnt_nxt;
   logic [7:0]        r_shift;
   logic [7:0]        w_shift_nxt;
   logic              r_line_high;
   logic              w_line_high_nxt;
   logic [1:0]        r_len;
   logic              r_par_en;
   logic              r_par_bit;
   logic              w_cfg_load;
   logic              r_par_sample;
   logic              w_par_sample_nxt;

   logic [7:0]        r_data;
   logic              r_vld;
   logic              r_perr;
   logic              r_ferr;
   logic              r_brk;
   logic              w_out_load;
   logic              w_perr_nxt;
   logic              w_ferr_nxt;
   logic              w_brk_nxt;

   uart_recv_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .sys_clk (sys_clk),
      .rst_b   (rst_b),
      .i_async (s_in),
      .o_sync  (w_s_sync)
   );

`ifdef UART_RECV_MAJORITY_EN
   logic [1:0] r_maj;

   // Remember the line at the two previous ticks for the majority vote
   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         r_maj <= 2'b11;
      end else if (recv_clk_en) begin
         r_maj <= {r_maj[0], w_s_sync};
      end
   end

   assign w_sample = maj3(r_maj[1], r_maj[0], w_s_sync);
`else
   assign w_sample = w_s_sync;
`endif

   // New sample enters at the MSB of the active width; data ends up right-justified
   always_comb begin
      w_shift_in = r_shift >> 1;
      w_shift_in[last_bit_idx(r_len)] = w_sample;
   end

   // State register
   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, counter and result computation; everything advances on ticks only
   always_comb begin
      w_state_nxt      = r_state;
      w_tick_nxt       = r_tick;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_shift_nxt      = r_shift;
      w_line_high_nxt  = r_line_high;
      w_cfg_load       = 1'b0;
      w_par_sample_nxt = r_par_sample;
      w_out_load       = 1'b0;
      w_perr_nxt       = 1'b0;
      w_ferr_nxt       = 1'b0;
      w_brk_nxt        = 1'b0;
      if (recv_clk_en) begin
         unique case (r_state)
            IDLE: begin
               if (w_s_sync) begin
                  w_line_high_nxt = 1'b1;
               end else if (r_line_high) begin
                  w_state_nxt     = START;
                  w_tick_nxt      = '0;
                  w_bit_cnt_nxt   = '0;
                  w_shift_nxt     = '0;
                  w_line_high_nxt = 1'b0;
                  w_cfg_load      = 1'b1;
               end
            end
            START: begin
               if (r_tick == START_SAMPLE) begin
                  w_tick_nxt = '0;
                  if (w_sample) begin
                     w_state_nxt     = IDLE;
                     w_line_high_nxt = 1'b1;
                  end else begin
                     w_state_nxt = DATA;
                  end
               end else begin
                  w_tick_nxt = r_tick + TICK_W'(1);
               end
            end
            DATA: begin
               if (r_tick == BIT_SAMPLE) begin
                  w_tick_nxt    = '0;
                  w_shift_nxt   = w_shift_in;
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == last_bit_idx(r_len)) begin
                     w_state_nxt = r_par_en ? PARITY : STOP;
                  end
               end else begin
                  w_tick_nxt = r_tick + TICK_W'(1);
               end
            end
            PARITY: begin
               if (r_tick == BIT_SAMPLE) begin
                  w_tick_nxt       = '0;
                  w_par_sample_nxt = w_sample;
                  w_state_nxt      = STOP;
               end else begin
                  w_tick_nxt = r_tick + TICK_W'(1);
               end
            end
            STOP: begin
               if (r_tick == BIT_SAMPLE) begin
                  w_tick_nxt  = '0;
                  w_state_nxt = IDLE;
                  w_out_load  = 1'b1;
                  // even mode (parity_bit=1) flags an odd total count of ones
                  w_perr_nxt  = r_par_en & ((^r_shift) ^ r_par_sample ^ ~r_par_bit);
                  w_ferr_nxt  = ~w_sample;
                  w_brk_nxt   = ~w_sample & (r_shift == 8'h00) & (~r_par_en | ~r_par_sample);
               end else begin
                  w_tick_nxt = r_tick + TICK_W'(1);
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // Frame datapath registers: counters, shifter, latched config and line flag
   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         r_tick       <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_line_high  <= 1'b0;
         r_len        <= LEN_5;
         r_par_en     <= 1'b0;
         r_par_bit    <= 1'b0;
         r_par_sample <= 1'b0;
      end else begin
         r_tick       <= w_tick_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_shift      <= w_shift_nxt;
         r_line_high  <= w_line_high_nxt;
         r_par_sample <= w_par_sample_nxt;
         if (w_cfg_load) begin
            r_len     <= ctrl_recv_data_length;
            r_par_en  <= ctrl_recv_parity_en;
            r_par_bit <= ctrl_recv_parity_bit;
         end
      end
   end

   // Result registers: loaded at the stop sample and held until the next character
   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         r_data <= '0;
         r_vld  <= 1'b0;
         r_perr <= 1'b0;
         r_ferr <= 1'b0;
         r_brk  <= 1'b0;
      end else begin
         r_vld <= w_out_load;
         if (w_out_load) begin
            r_data <= r_shift;
            r_perr <= w_perr_nxt;
            r_ferr <= w_ferr_nxt;
            r_brk  <= w_brk_nxt;
         end
      end
   end

   assign recv_ctrl_data       = r_data;
   assign recv_ctrl_data_vld   = r_vld;
   assign recv_ctrl_parity_err = r_perr;
   assign recv_ctrl_frame_err  = r_ferr;
   assign recv_ctrl_break      = r_brk;
   assign recv_ctrl_busy       = (r_state != IDLE);

endmodule
